// File: rtl/mem_port_arbiter.sv
// Shares one synchronous-read memory port between requesters A and B (IDLE -> ISSUE [-> RDATA]).
// Build option: define MEM_ARB_FIXED_PRIORITY_EN to give A fixed priority instead of round-robin.
module mem_port_arbiter #(
    parameter int WORD_SIZE     = 16,
    parameter int MEM_ADDR_SIZE = 8
) (
    input  logic                     clock,
    input  logic                     reset,

    input  logic                     a_req,
    input  logic                     a_write,
    input  logic [MEM_ADDR_SIZE-1:0] a_addr,
    input  logic [WORD_SIZE-1:0]     a_wdata,
    output logic                     a_gnt,
    output logic                     a_rvalid,
    output logic [WORD_SIZE-1:0]     a_rdata,

    input  logic                     b_req,
    input  logic                     b_write,
    input  logic [MEM_ADDR_SIZE-1:0] b_addr,
    input  logic [WORD_SIZE-1:0]     b_wdata,
    output logic                     b_gnt,
    output logic                     b_rvalid,
    output logic [WORD_SIZE-1:0]     b_rdata,

    output logic [MEM_ADDR_SIZE-1:0] mem_address,
    output logic [WORD_SIZE-1:0]     mem_write_data,
    output logic                     mem_read,
    output logic                     mem_write,
    input  logic [WORD_SIZE-1:0]     mem_read_data,

    output logic                     busy,
    output logic                     owner
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] RDATA = 2'd2;

    logic [1:0]               state_reg;
    logic [1:0]               state_next;
    logic                     lat_write_reg;
    logic [MEM_ADDR_SIZE-1:0] lat_addr_reg;
    logic [WORD_SIZE-1:0]     lat_wdata_reg;
    logic                     owner_reg;
    logic                     a_rvalid_reg;
    logic                     b_rvalid_reg;
    logic [WORD_SIZE-1:0]     a_rdata_reg;
    logic [WORD_SIZE-1:0]     b_rdata_reg;
    logic                     any_req;
    logic                     winner;
    logic                     issue;
    logic                     grant_now;

    assign any_req   = a_req | b_req;
    assign issue     = (state_reg == ISSUE);
    assign grant_now = (state_reg == IDLE) && any_req;

`ifdef MEM_ARB_FIXED_PRIORITY_EN
    // A always wins; B only gets the port when A is not asking.
    assign winner = ~a_req;
`else
    logic last_grant_reg;

    // On a tie the port that did not win last time goes next.
    assign winner = (a_req & b_req) ? ~last_grant_reg : b_req;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_grant_reg <= 1'b1;
        end else if (grant_now) begin
            last_grant_reg <= winner;
        end
    end
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    state_next = any_req ? ISSUE : IDLE;
            ISSUE:   state_next = lat_write_reg ? IDLE : RDATA;
            RDATA:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            lat_write_reg <= 1'b0;
            lat_addr_reg  <= '0;
            lat_wdata_reg <= '0;
            owner_reg     <= 1'b0;
            a_rvalid_reg  <= 1'b0;
            b_rvalid_reg  <= 1'b0;
            a_rdata_reg   <= '0;
            b_rdata_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            a_rvalid_reg <= 1'b0;
            b_rvalid_reg <= 1'b0;
            if (grant_now) begin
                owner_reg     <= winner;
                lat_write_reg <= winner ? b_write : a_write;
                lat_addr_reg  <= winner ? b_addr  : a_addr;
                lat_wdata_reg <= winner ? b_wdata : a_wdata;
            end
            // Memory data arrives one cycle after the ISSUE strobe, i.e. during RDATA.
            if (state_reg == RDATA) begin
                if (owner_reg) begin
                    b_rdata_reg  <= mem_read_data;
                    b_rvalid_reg <= 1'b1;
                end else begin
                    a_rdata_reg  <= mem_read_data;
                    a_rvalid_reg <= 1'b1;
                end
            end
        end
    end

    assign a_gnt          = issue & ~owner_reg;
    assign b_gnt          = issue &  owner_reg;
    assign mem_address    = issue ? lat_addr_reg  : '0;
    assign mem_write_data = issue ? lat_wdata_reg : '0;
    assign mem_read       = issue & ~lat_write_reg;
    assign mem_write      = issue &  lat_write_reg;
    assign a_rvalid       = a_rvalid_reg;
    assign b_rvalid       = b_rvalid_reg;
    assign a_rdata        = a_rdata_reg;
    assign b_rdata        = b_rdata_reg;
    assign busy           = (state_reg != IDLE);
    assign owner          = owner_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: timeline-level reference model of grants, latency and data.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int W    = 16;
    localparam int AW   = 8;
    localparam int NCYC = 600;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          a_req = 1'b0, a_write = 1'b0, b_req = 1'b0, b_write = 1'b0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [W-1:0]  a_wdata = '0, b_wdata = '0;
    logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [W-1:0]  a_rdata, b_rdata;
    logic [AW-1:0] mem_address;
    logic [W-1:0]  mem_write_data, mem_read_data;
    logic          mem_read, mem_write, busy, owner;

    logic [W-1:0]  tb_mem  [256];
    logic [W-1:0]  ref_mem [256];

    int n_compared   = 0;
    int n_mismatched = 0;
    int cyc          = 0;

    // Reference timeline: the latest grant, its read-return, and when the arbiter is next free.
    int            g_cycle, g_port, free_at, rv_cycle, rv_port, last;
    logic          g_write, exp_owner;
    logic [AW-1:0] g_addr;
    logic [W-1:0]  g_wdata, rv_data, exp_a_rdata, exp_b_rdata;
    bit            a_pend, b_pend, a_cool, b_cool, did_reset, issue;
    int            win;

    always #5 clock = ~clock;

    mem_port_arbiter #(.WORD_SIZE(W), .MEM_ADDR_SIZE(AW)) dut (
        .clock(clock), .reset(reset),
        .a_req(a_req), .a_write(a_write), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_write(b_write), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_read(mem_read), .mem_write(mem_write), .mem_read_data(mem_read_data),
        .busy(busy), .owner(owner)
    );

    // Synchronous-read memory, reloaded with data = addr + 0x100 while reset is held.
    always @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < 256; i++) tb_mem[i] <= W'(i + 'h100);
        end else begin
            if (mem_write) tb_mem[mem_address] <= mem_write_data;
            if (mem_read)  mem_read_data <= tb_mem[mem_address];
        end
    end

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check_value({tag, "_flags"}, {a_gnt, b_gnt, a_rvalid, b_rvalid, mem_read, mem_write, busy, owner}, 0);
        check_value({tag, "_a_rdata"}, a_rdata, 0);
        check_value({tag, "_b_rdata"}, b_rdata, 0);
        check_value({tag, "_mem_address"}, mem_address, 0);
        check_value({tag, "_mem_write_data"}, mem_write_data, 0);
    endtask

    task automatic model_reset(input int resume);
        for (int i = 0; i < 256; i++) ref_mem[i] = W'(i + 'h100);
        g_cycle = -1; g_port = 0; g_write = 1'b0; g_addr = '0; g_wdata = '0;
        free_at = resume; rv_cycle = -1; rv_port = 0; rv_data = '0;
        exp_a_rdata = '0; exp_b_rdata = '0; exp_owner = 1'b0; last = 1;
    endtask

    initial begin
        model_reset(0);
        a_pend = 0; b_pend = 0; a_cool = 0; b_cool = 0; did_reset = 0;
        #2 check_zero("reset_state");
        repeat (2) @(posedge clock);

        for (cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clock);
            #1 reset = 1'b1;
            // Requesters: hold fields until granted, then drop req for one cycle.
            if (a_cool) a_cool = 0;
            else if (!a_pend && $urandom_range(0, 1) == 1) begin
                a_pend = 1; a_write = 1'($urandom_range(0, 1));
                a_addr = AW'($urandom_range(0, 15)); a_wdata = W'($urandom);
            end
            if (b_cool) b_cool = 0;
            else if (!b_pend && $urandom_range(0, 1) == 1) begin
                b_pend = 1; b_write = 1'($urandom_range(0, 1));
                b_addr = AW'($urandom_range(0, 15)); b_wdata = W'($urandom);
            end
            a_req = a_pend;
            b_req = b_pend;

            @(negedge clock);
            issue = (cyc == g_cycle);
            if (issue) exp_owner = 1'(g_port);
            if (cyc == rv_cycle) begin
                if (rv_port == 0) exp_a_rdata = rv_data;
                else              exp_b_rdata = rv_data;
            end
            check_value("a_gnt", a_gnt, issue && g_port == 0);
            check_value("b_gnt", b_gnt, issue && g_port == 1);
            check_value("mem_read", mem_read, issue && !g_write);
            check_value("mem_write", mem_write, issue && g_write);
            check_value("mem_address", mem_address, issue ? g_addr : 0);
            check_value("mem_write_data", mem_write_data, issue ? g_wdata : 0);
            check_value("busy", busy, g_cycle >= 0 && cyc >= g_cycle && cyc < free_at);
            check_value("a_rvalid", a_rvalid, cyc == rv_cycle && rv_port == 0);
            check_value("b_rvalid", b_rvalid, cyc == rv_cycle && rv_port == 1);
            check_value("a_rdata", a_rdata, exp_a_rdata);
            check_value("b_rdata", b_rdata, exp_b_rdata);
            check_value("owner", owner, exp_owner);

            if (a_gnt) begin a_pend = 0; a_cool = 1; end
            if (b_gnt) begin b_pend = 0; b_cool = 1; end

            // Arbitration decision for a request seen while the arbiter is free.
            if (cyc >= free_at && (a_req || b_req)) begin
`ifdef MEM_ARB_FIXED_PRIORITY_EN
                win = a_req ? 0 : 1;
`else
                if (a_req && b_req) win = 1 - last;
                else                win = a_req ? 0 : 1;
`endif
                last    = win;
                g_cycle = cyc + 1;
                g_port  = win;
                g_write = win ? b_write : a_write;
                g_addr  = win ? b_addr  : a_addr;
                g_wdata = win ? b_wdata : a_wdata;
                if (g_write) begin
                    ref_mem[g_addr] = g_wdata;
                    free_at = cyc + 2;
                end else begin
                    rv_cycle = cyc + 3;
                    rv_port  = win;
                    rv_data  = ref_mem[g_addr];
                    free_at  = cyc + 3;
                end
            end

            // Once, pull reset in the RDATA cycle of an A read and check the outputs clear at once.
            if (!did_reset && cyc > 150 && rv_port == 0 && cyc == rv_cycle - 1) begin
                did_reset = 1;
                #1 reset = 1'b0;
                #1 check_zero("async_reset");
                model_reset(cyc + 1);
                a_pend = 1; a_cool = 0; a_write = 1'b0;
                a_addr = AW'($urandom_range(0, 15));
                a_req  = 1'b1;
            end
        end

        check_value("reset_scenario_hit", did_reset, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
